// File: rtl/aig_mix_bist_ctrl.sv
// BIST driver for the 80-in/40-out AIG benchmarks: an LFSR generates stimulus and a MISR
// compacts the responses into a signature, which is then compared against a golden value.
module aig_mix_bist_ctrl #(
  parameter int unsigned PATTERNS = 256,
  parameter logic [79:0] SEED     = 80'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [39:0] golden_sig,
  output logic [79:0] stim,
  input  logic [39:0] resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [39:0] signature,
  output logic [15:0] pat_count
);

  // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
  localparam logic [79:0] SEED_EFF = (SEED == 80'h0) ? 80'h1 : SEED;
  localparam logic [15:0] LAST_PAT = 16'(PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [39:0] misr;
  logic        fb_l;
  logic        fb_m;
  logic [79:0] stim_nxt;
  logic [39:0] misr_nxt;

  assign fb_l      = stim[79] ^ stim[78] ^ stim[42] ^ stim[41];
  assign fb_m      = misr[39] ^ misr[37] ^ misr[20] ^ misr[18];
  assign stim_nxt  = {stim[78:0], fb_l};
  assign misr_nxt  = {misr[38:0], fb_m} ^ resp;
  assign signature = misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stim      <= '0;
      misr      <= '0;
      pat_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Datapath freezes where it was; only the control state unwinds.
        state <= IDLE;
        busy  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= RUN;
              busy      <= 1'b1;
              stim      <= SEED_EFF;
              misr      <= '0;
              pat_count <= '0;
              pass      <= 1'b0;
            end
          end
          RUN: begin
            misr      <= misr_nxt;
            stim      <= stim_nxt;
            pat_count <= pat_count + 16'd1;
            if (pat_count == LAST_PAT) begin
              // Compare against the post-compaction value so pass lines up with done.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (misr_nxt == golden_sig);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aig_mix_bist_ctrl.sv
// Directed bench for aig_mix_bist_ctrl: four instances with different run lengths,
// one of them wrapped around a small combinational block under test.
module tb_aig_mix_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  localparam logic [79:0] SEED_D = 80'hACE1_2345_6789_0000_BEEF;

  // a: 45 patterns, b: 2 patterns, c: 1 pattern (zero seed), d: 256 patterns on a real block
  logic        start_a = 0, abort_a = 0, busy_a, done_a, pass_a;
  logic [39:0] golden_a = '0, resp_a, sig_a;
  logic [79:0] stim_a;
  logic [15:0] cnt_a;
  logic        start_b = 0, abort_b = 0, busy_b, done_b, pass_b;
  logic [39:0] golden_b = '0, resp_b, sig_b;
  logic [79:0] stim_b;
  logic [15:0] cnt_b;
  logic        start_c = 0, abort_c = 0, busy_c, done_c, pass_c;
  logic [39:0] golden_c = '0, resp_c, sig_c;
  logic [79:0] stim_c;
  logic [15:0] cnt_c;
  logic        start_d = 0, abort_d = 0, busy_d, done_d, pass_d;
  logic [39:0] golden_d = '0, resp_d, sig_d;
  logic [79:0] stim_d;
  logic [15:0] cnt_d;

  function automatic logic [79:0] lfsr_step(input logic [79:0] s);
    return {s[78:0], s[79] ^ s[78] ^ s[42] ^ s[41]};
  endfunction

  function automatic logic [39:0] misr_step(input logic [39:0] m, input logic [39:0] r);
    return {m[38:0], m[39] ^ m[37] ^ m[20] ^ m[18]} ^ r;
  endfunction

  // Stand-in combinational benchmark: mixed AND/OR/XOR of scattered inputs.
  function automatic logic [39:0] cut(input logic [79:0] s);
    logic [39:0] r;
    for (int i = 0; i < 40; i++)
      r[i] = (s[i] & ~s[i+40]) ^ (s[(2*i+5)%80] | s[(i+17)%80]);
    return r;
  endfunction

  function automatic logic [39:0] model_sig(input logic [79:0] seed, input int n);
    logic [79:0] s;
    logic [39:0] m;
    s = seed;
    m = '0;
    for (int k = 0; k < n; k++) begin
      m = misr_step(m, cut(s));
      s = lfsr_step(s);
    end
    return m;
  endfunction

  assign resp_a = 40'h0;
  assign resp_b = 40'h1;
  assign resp_c = 40'h1;
  assign resp_d = cut(stim_d);

  aig_mix_bist_ctrl #(.PATTERNS(45), .SEED(80'h1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .golden_sig(golden_a),
    .stim(stim_a), .resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_count(cnt_a));
  aig_mix_bist_ctrl #(.PATTERNS(2), .SEED(80'h1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .golden_sig(golden_b),
    .stim(stim_b), .resp(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_count(cnt_b));
  aig_mix_bist_ctrl #(.PATTERNS(1), .SEED(80'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .golden_sig(golden_c),
    .stim(stim_c), .resp(resp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_count(cnt_c));
  aig_mix_bist_ctrl #(.PATTERNS(256), .SEED(SEED_D)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .golden_sig(golden_d),
    .stim(stim_d), .resp(resp_d), .busy(busy_d), .done(done_d), .pass(pass_d),
    .signature(sig_d), .pat_count(cnt_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [79:0] one80;
    logic [79:0] s_exp;
    logic [39:0] sig256;
    one80 = 80'h1;
    sig256 = model_sig(SEED_D, 256);

    // Reset held with start toggling: nothing may move.
    for (int i = 0; i < 4; i++) begin
      start_a = i[0];
      start_d = i[0];
      tick();
      chk("rst_stim", stim_a, 80'h0);
      chk("rst_sig", {40'h0, sig_a}, 80'h0);
      chk("rst_flags", {busy_a, done_a, pass_a, cnt_a}, 80'h0);
      chk("rst_busy_d", {79'h0, busy_d}, 80'h0);
    end
    start_a = 0;
    start_d = 0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_flags", {busy_a, done_a, pass_a, cnt_a}, 80'h0);
    chk("idle_stim", stim_a, 80'h0);

    // LFSR sequence, resp=0, golden=0.
    start_a = 1;
    tick();
    start_a = 0;
    chk("a_busy", {79'h0, busy_a}, 80'h1);
    for (int k = 0; k < 45; k++) begin
      if (k <= 41) chk("a_stim_walk", stim_a, one80 << k);
      else if (k == 42) chk("a_stim_fb", stim_a, (one80 << 42) | one80);
      tick();
    end
    chk("a_done", {78'h0, done_a, busy_a}, 80'h2);
    chk("a_sig", {40'h0, sig_a}, 80'h0);
    chk("a_pass", {79'h0, pass_a}, 80'h1);
    chk("a_cnt", {64'h0, cnt_a}, 80'd45);

    // MISR arithmetic with resp=1, first a matching golden then a mismatching one.
    golden_b = 40'h3;
    start_b = 1;
    tick();
    start_b = 0;
    tick();
    chk("b_t2", {78'h0, busy_b, done_b}, 80'h2);
    tick();
    chk("b_t3_done", {78'h0, busy_b, done_b}, 80'h1);
    chk("b_sig", {40'h0, sig_b}, 80'h3);
    chk("b_pass", {79'h0, pass_b}, 80'h1);
    tick();
    chk("b_after", {78'h0, done_b, pass_b}, 80'h1);
    golden_b = 40'h2;
    start_b = 1;
    tick();
    start_b = 0;
    chk("b_pass_clr", {79'h0, pass_b}, 80'h0);
    repeat (2) tick();
    chk("b_done2", {79'h0, done_b}, 80'h1);
    chk("b_sig2", {40'h0, sig_b}, 80'h3);
    chk("b_fail", {79'h0, pass_b}, 80'h0);
    tick();

    // start and abort on the same edge in IDLE: abort wins.
    start_b = 1;
    abort_b = 1;
    tick();
    start_b = 0;
    abort_b = 0;
    chk("b_abort_wins", {78'h0, busy_b, done_b}, 80'h0);

    // Single pattern, zero seed replaced by 1.
    golden_c = 40'h1;
    start_c = 1;
    tick();
    start_c = 0;
    chk("c_seed", stim_c, 80'h1);
    chk("c_t1", {78'h0, busy_c, done_c}, 80'h2);
    tick();
    chk("c_t2", {78'h0, busy_c, done_c}, 80'h1);
    chk("c_sig", {40'h0, sig_c}, 80'h1);
    chk("c_cnt", {64'h0, cnt_c}, 80'd1);
    chk("c_pass", {79'h0, pass_c}, 80'h1);

    // Abort in cycle T+10 of a 256-pattern run.
    golden_d = sig256;
    start_d = 1;
    tick();
    start_d = 0;
    repeat (9) tick();
    abort_d = 1;
    tick();
    abort_d = 0;
    s_exp = SEED_D;
    for (int k = 0; k < 9; k++) s_exp = lfsr_step(s_exp);
    chk("d_abort_cnt", {64'h0, cnt_d}, 80'd9);
    chk("d_abort_stim", stim_d, s_exp);
    chk("d_abort_sig", {40'h0, sig_d}, {40'h0, model_sig(SEED_D, 9)});
    for (int i = 0; i < 4; i++) begin
      chk("d_abort_idle", {77'h0, busy_d, done_d, pass_d}, 80'h0);
      tick();
    end
    chk("d_abort_frozen", {64'h0, cnt_d}, 80'd9);

    // Restart and two full runs with no reset between them.
    for (int run = 0; run < 2; run++) begin
      start_d = 1;
      tick();
      start_d = 0;
      chk("d_restart_stim", stim_d, SEED_D);
      chk("d_restart_cnt", {64'h0, cnt_d}, 80'd0);
      chk("d_restart_busy", {78'h0, busy_d, pass_d}, 80'h2);
      repeat (255) tick();
      chk("d_last_busy", {78'h0, busy_d, done_d}, 80'h2);
      tick();
      chk("d_done", {78'h0, busy_d, done_d}, 80'h1);
      chk("d_sig", {40'h0, sig_d}, {40'h0, sig256});
      chk("d_pass", {79'h0, pass_d}, 80'h1);
      chk("d_cnt", {64'h0, cnt_d}, 80'd256);
      tick();
      chk("d_idle", {77'h0, busy_d, done_d, pass_d}, 80'h1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
